serial_add_seq: RTL

Bit-serial add/subtract sequencer. A single 1-bit full-adder cell is time-shared across the bits of a WIDTH-bit operand pair, one bit per clock, LSB first. The block captures operands on a start handshake, feeds each bit pair and the registered carry through the cell, and shifts result bits into a result register. It reports completion with a one-cycle `done` pulse. It is the area-minimal arithmetic unit for datapaths that tolerate WIDTH-cycle latency.

---
 rtl/serial_add_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell time-shared across
// WIDTH bits, LSB first, one bit per clock, with a one-cycle done pulse.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic cell_x, cell_y, cell_s, cell_co;

  // Shared full-adder cell; B is inverted for subtract, carry-in comes from c_q
  always_comb begin
    cell_x  = ra_q[0];
    cell_y  = rb_q[0] ^ sub_q;
    cell_s  = cell_x ^ cell_y ^ c_q;
    cell_co = (cell_x & cell_y) | (cell_x & c_q) | (cell_y & c_q);
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      RUN: begin
        res_d = {cell_s, res_q[WIDTH-1:1]};
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        c_d   = cell_co;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // c_q here is the carry into the MSB
          cout_d  = cell_co;
          ovf_d   = c_q ^ cell_co;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          sub_d   = sub;
          c_d     = sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
